// File: rtl/ram_access_arbiter.sv
// Two-requester arbiter in front of a single-port-pair RAM, with a full-RAM zero-fill sequencer.
// Optional build macro RAM_ARB_FIXED_PRIO_EN: req0 always wins ties (no round-robin pointer).
module ram_access_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 32,
  localparam int unsigned RW        = $clog2(ROWS),
  localparam int unsigned CW        = $clog2(COLS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [RW-1:0]         req0_row,
  input  logic [CW-1:0]         req0_col,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [RW-1:0]         req1_row,
  input  logic [CW-1:0]         req1_col,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  ram_we,
  output logic [RW-1:0]         ram_w_row,
  output logic [CW-1:0]         ram_w_col,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [RW-1:0]         ram_r_row,
  output logic [CW-1:0]         ram_r_col,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  typedef enum logic {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e                  state_q;
  logic                    ram_we_q;
  logic [RW-1:0]           w_row_q;
  logic [CW-1:0]           w_col_q;
  logic [DATA_WIDTH-1:0]   din_q;
  logic [RW-1:0]           r_row_q;
  logic [CW-1:0]           r_col_q;
  logic                    rd_pend_q;
  logic                    rd_id_q;
  logic                    rsp0_valid_q;
  logic                    rsp1_valid_q;
  logic [DATA_WIDTH-1:0]   rsp0_hold_q;
  logic [DATA_WIDTH-1:0]   rsp1_hold_q;
  logic                    clr_busy_q;
  logic                    clr_done_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
  logic                    prio1_q;
`endif

  logic                    gnt0_c;
  logic                    gnt1_c;
  logic                    xfer_c;
  logic                    x_we_c;
  logic [RW-1:0]           x_row_c;
  logic [CW-1:0]           x_col_c;
  logic [DATA_WIDTH-1:0]   x_wdata_c;

  // Grant decision: only while serving, never in reset or while a clear is requested
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (rst_n && (state_q == SERVE) && !clr_start) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      gnt0_c = req0_valid;
      gnt1_c = req1_valid && !req0_valid;
`else
      gnt0_c = req0_valid && (!req1_valid || !prio1_q);
      gnt1_c = req1_valid && (!req0_valid || prio1_q);
`endif
    end
  end

  assign xfer_c    = gnt0_c | gnt1_c;
  assign x_we_c    = gnt1_c ? req1_we    : req0_we;
  assign x_row_c   = gnt1_c ? req1_row   : req0_row;
  assign x_col_c   = gnt1_c ? req1_col   : req0_col;
  assign x_wdata_c = gnt1_c ? req1_wdata : req0_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= SERVE;
      ram_we_q     <= 1'b0;
      w_row_q      <= '0;
      w_col_q      <= '0;
      din_q        <= '0;
      r_row_q      <= '0;
      r_col_q      <= '0;
      rd_pend_q    <= 1'b0;
      rd_id_q      <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_hold_q  <= '0;
      rsp1_hold_q  <= '0;
      clr_busy_q   <= 1'b0;
      clr_done_q   <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      prio1_q      <= 1'b0;
`endif
    end else begin
      ram_we_q     <= 1'b0;
      clr_done_q   <= 1'b0;
      rd_pend_q    <= 1'b0;
      // Read response pipeline keeps running through a clear
      rsp0_valid_q <= rd_pend_q && !rd_id_q;
      rsp1_valid_q <= rd_pend_q && rd_id_q;
      if (rsp0_valid_q) rsp0_hold_q <= ram_dout;
      if (rsp1_valid_q) rsp1_hold_q <= ram_dout;

      case (state_q)
        SERVE: begin
          if (clr_start) begin
            state_q    <= CLEAR;
            clr_busy_q <= 1'b1;
            ram_we_q   <= 1'b1;
            w_row_q    <= '0;
            w_col_q    <= '0;
            din_q      <= '0;
          end else if (xfer_c) begin
            if (x_we_c) begin
              ram_we_q <= 1'b1;
              w_row_q  <= x_row_c;
              w_col_q  <= x_col_c;
              din_q    <= x_wdata_c;
            end else begin
              rd_pend_q <= 1'b1;
              rd_id_q   <= gnt1_c;
              r_row_q   <= x_row_c;
              r_col_q   <= x_col_c;
            end
`ifndef RAM_ARB_FIXED_PRIO_EN
            prio1_q <= gnt0_c;
`endif
          end
        end
        CLEAR: begin
          // Write address doubles as the fill counter, column fastest
          if ((w_row_q == LAST_ROW) && (w_col_q == LAST_COL)) begin
            state_q    <= SERVE;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end else begin
            ram_we_q <= 1'b1;
            if (w_col_q == LAST_COL) begin
              w_col_q <= '0;
              w_row_q <= w_row_q + RW'(1);
            end else begin
              w_col_q <= w_col_q + CW'(1);
            end
          end
        end
        default: state_q <= SERVE;
      endcase
    end
  end

  assign req0_ready = gnt0_c;
  assign req1_ready = gnt1_c;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  // Response data is live RAM output in the response cycle, held afterwards
  assign rsp0_rdata = rsp0_valid_q ? ram_dout : rsp0_hold_q;
  assign rsp1_rdata = rsp1_valid_q ? ram_dout : rsp1_hold_q;
  assign clr_busy   = clr_busy_q;
  assign clr_done   = clr_done_q;
  assign ram_we     = ram_we_q;
  assign ram_w_row  = w_row_q;
  assign ram_w_col  = w_col_q;
  assign ram_din    = din_q;
  assign ram_r_row  = r_row_q;
  assign ram_r_col  = r_col_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter: random and directed traffic against a cell-array model.
module tb_ram_access_arbiter;
  localparam int DW = 8;
  localparam int RW = 2;
  localparam int CW = 5;
  localparam int NCELL = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
  logic [RW-1:0] req0_row = '0, req1_row = '0;
  logic [CW-1:0] req0_col = '0, req1_col = '0;
  logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
  logic clr_start = 1'b0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, clr_busy, clr_done, ram_we;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata, ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic [RW-1:0] ram_w_row, ram_r_row;
  logic [CW-1:0] ram_w_col, ram_r_col;

  ram_access_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_row(req0_row), .req0_col(req0_col), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_row(req1_row), .req1_col(req1_col), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_we(ram_we), .ram_w_row(ram_w_row), .ram_w_col(ram_w_col), .ram_din(ram_din),
    .ram_r_row(ram_r_row), .ram_r_col(ram_r_col), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Synchronous RAM behind the arbiter
  logic [DW-1:0] ram_mem [NCELL] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_we) ram_mem[{ram_w_row, ram_w_col}] <= ram_din;
    ram_dout <= ram_mem[{ram_r_row, ram_r_col}];
  end

  typedef struct packed {
    logic          v;
    logic          we;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } req_t;
  typedef struct { int due; logic [6:0] idx; logic [DW-1:0] data; } wexp_t;
  typedef struct { int due; logic [DW-1:0] data; } rexp_t;

  wexp_t wq[$];
  rexp_t rq0[$], rq1[$];
  int glog[$];
  logic [DW-1:0] ref_mem [NCELL];
  int cyc = 0;
  int clr_s = -100000;
  bit last1 = 1'b1;
  bit mon_en = 1'b0;
  int checks = 0;
  int failures = 0;
  req_t cur_a, cur_b;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic req_t rnd_req();
    req_t q;
    q.v  = ($urandom_range(0, 3) != 0);
    q.we = 1'($urandom_range(0, 1));
    q.r  = RW'($urandom_range(0, 3));
    q.c  = CW'($urandom_range(0, 31));
    q.d  = DW'($urandom);
    return q;
  endfunction

  function automatic req_t mk(input bit v, input bit we, input int r, input int c, input int d);
    req_t q;
    q.v = v; q.we = we; q.r = RW'(r); q.c = CW'(c); q.d = DW'(d);
    return q;
  endfunction

  function automatic bit in_clear(input int c);
    return (c >= clr_s) && (c < clr_s + NCELL);
  endfunction

  // One cycle of stimulus; the model decides grants and queues expected outputs
  task automatic drive(input req_t a, input req_t b, input bit clr, output bit g0, output bit g1);
    int c;
    int win;
    logic [6:0] idx;
    req_t w;
    @(negedge clk);
    req0_valid = a.v; req0_we = a.we; req0_row = a.r; req0_col = a.c; req0_wdata = a.d;
    req1_valid = b.v; req1_we = b.we; req1_row = b.r; req1_col = b.c; req1_wdata = b.d;
    clr_start = clr;
    #1;
    c = cyc;
    win = -1;
    if (!in_clear(c) && !clr) begin
      if (a.v && b.v) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        win = 0;
`else
        win = last1 ? 0 : 1;
`endif
      end else if (a.v) win = 0;
      else if (b.v) win = 1;
    end
    g0 = (win == 0);
    g1 = (win == 1);
    chk("req0_ready", 32'(req0_ready), 32'(g0));
    chk("req1_ready", 32'(req1_ready), 32'(g1));
    if (win >= 0) begin
      w = (win == 0) ? a : b;
      idx = {w.r, w.c};
      last1 = (win == 1);
      glog.push_back(win);
      if (w.we) begin
        ref_mem[idx] = w.d;
        wq.push_back('{c + 1, idx, w.d});
      end else if (win == 0) begin
        rq0.push_back('{c + 2, ref_mem[idx]});
      end else begin
        rq1.push_back('{c + 2, ref_mem[idx]});
      end
    end
    if (clr && !in_clear(c)) begin
      clr_s = c + 1;
      for (int k = 0; k < NCELL; k++) begin
        wq.push_back('{c + 1 + k, 7'(k), 8'h00});
        ref_mem[k] = 8'h00;
      end
    end
  endtask

  task automatic run_random(input int n, input int clr_mod);
    bit g0, g1, clr;
    for (int i = 0; i < n; i++) begin
      clr = (clr_mod > 0) && ($urandom_range(0, clr_mod - 1) == 0);
      drive(cur_a, cur_b, clr, g0, g1);
      if (!(cur_a.v && !g0)) cur_a = rnd_req();
      if (!(cur_b.v && !g1)) cur_b = rnd_req();
    end
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_ready0"}, 32'(req0_ready), 0);
    chk({tag, "_ready1"}, 32'(req1_ready), 0);
    chk({tag, "_rsp0v"}, 32'(rsp0_valid), 0);
    chk({tag, "_rsp1v"}, 32'(rsp1_valid), 0);
    chk({tag, "_rsp0d"}, 32'(rsp0_rdata), 0);
    chk({tag, "_rsp1d"}, 32'(rsp1_rdata), 0);
    chk({tag, "_busy"}, 32'(clr_busy), 0);
    chk({tag, "_done"}, 32'(clr_done), 0);
    chk({tag, "_we"}, 32'(ram_we), 0);
    chk({tag, "_waddr"}, 32'({ram_w_row, ram_w_col}), 0);
    chk({tag, "_din"}, 32'(ram_din), 0);
    chk({tag, "_raddr"}, 32'({ram_r_row, ram_r_col}), 0);
  endtask

  // Monitor: pops expectations when due, otherwise demands idle outputs
  always @(posedge clk) begin
    wexp_t w;
    rexp_t r;
    #1;
    if (mon_en) begin
      chk("clr_busy", 32'(clr_busy), 32'(in_clear(cyc)));
      chk("clr_done", 32'(clr_done), 32'(cyc == clr_s + NCELL));
      if (wq.size() != 0 && wq[0].due == cyc) begin
        w = wq.pop_front();
        chk("ram_we", 32'(ram_we), 1);
        chk("ram_waddr", 32'({ram_w_row, ram_w_col}), 32'(w.idx));
        chk("ram_din", 32'(ram_din), 32'(w.data));
      end else chk("ram_we_idle", 32'(ram_we), 0);
      if (rq0.size() != 0 && rq0[0].due == cyc) begin
        r = rq0.pop_front();
        chk("rsp0_valid", 32'(rsp0_valid), 1);
        chk("rsp0_rdata", 32'(rsp0_rdata), 32'(r.data));
      end else chk("rsp0_idle", 32'(rsp0_valid), 0);
      if (rq1.size() != 0 && rq1[0].due == cyc) begin
        r = rq1.pop_front();
        chk("rsp1_valid", 32'(rsp1_valid), 1);
        chk("rsp1_rdata", 32'(rsp1_rdata), 32'(r.data));
      end else chk("rsp1_idle", 32'(rsp1_valid), 0);
    end
  end

  initial begin
    bit g0, g1;
    int n;
    int exp_g[4];
    req_t idle;
    idle = '0;
    cur_a = '0;
    cur_b = '0;
    for (int k = 0; k < NCELL; k++) ref_mem[k] = 8'h00;

    // Reset with requests pending: nothing may be granted
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    zero_chk("reset");
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    mon_en = 1'b1;

    // Both requesters reading continuously
`ifdef RAM_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    glog.delete();
    n = 0;
    while (glog.size() < 4 && n < 8) begin
      drive(mk(1, 0, 0, n, 0), mk(1, 0, 1, n, 0), 1'b0, g0, g1);
      n++;
    end
    chk("grant_count", 32'(glog.size()), 4);
    for (int k = 0; k < 4 && k < glog.size(); k++) chk("grant_order", 32'(glog[k]), 32'(exp_g[k]));

    // Write then immediate read of the same cell
    drive(mk(1, 1, 1, 5, 8'hA5), idle, 1'b0, g0, g1);
    drive(mk(1, 0, 1, 5, 0), idle, 1'b0, g0, g1);
    chk("a5_model", 32'(ref_mem[{2'd1, 5'd5}]), 32'h00A5);

    // Fill every cell with 0xFF
    for (int k = 0; k < NCELL; k++) drive(mk(1, 1, k / 32, k % 32, 8'hFF), idle, 1'b0, g0, g1);

    // Read accepted just before a clear returns pre-clear data
    drive(idle, mk(1, 0, 2, 7, 0), 1'b0, g0, g1);
    drive(idle, idle, 1'b1, g0, g1);
    run_random(120, 8);
    run_random(20, 0);

    // Every cell reads back zero unless rewritten since the clear
    for (int k = 0; k < NCELL; k++) drive(mk(1, 0, k / 32, k % 32, 0), idle, 1'b0, g0, g1);

    cur_a = '0;
    cur_b = '0;
    run_random(900, 64);

    // Drain: bounded wait for the clear and all expected outputs to finish
    n = 0;
    while ((in_clear(cyc) || wq.size() != 0 || rq0.size() != 0 || rq1.size() != 0) && n < 200) begin
      drive(idle, idle, 1'b0, g0, g1);
      n++;
    end
    drive(idle, idle, 1'b0, g0, g1);
    chk("drain_empty", 32'(wq.size() + rq0.size() + rq1.size()), 0);

    // Reset one cycle after a read is accepted cancels its response
    drive(mk(1, 0, 3, 3, 0), idle, 1'b0, g0, g1);
    chk("pre_reset_grant", 32'(g0), 1);
    mon_en = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    zero_chk("midrd_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("post_reset_rsp0", 32'(rsp0_valid), 0);
      chk("post_reset_rsp1", 32'(rsp1_valid), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
